// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and zero/parity flags.
// Optional accumulate mode (A taken from last result) enabled by defining LOGIC_UNIT_ACC_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
`ifdef LOGIC_UNIT_ACC_EN
  input  logic             acc_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             zero,
  output logic             parity
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [2:0]       op_q, op_d;
  logic             s1_v_q, s1_v_d, out_valid_q, out_valid_d;
  logic             zero_q, zero_d, parity_q, parity_d;
  logic             s1_load, s2_load;
  logic [WIDTH-1:0] opa, res;
`ifdef LOGIC_UNIT_ACC_EN
  logic             acc_sel_q, acc_sel_d;
`endif

  // S2 frees up in the same cycle it is drained, so a full pipe keeps streaming.
  assign s2_load  = s1_v_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_v_q | ~out_valid_q | out_ready;
  assign s1_load  = in_valid & in_ready;

  always_comb begin
    opa = a_q;
`ifdef LOGIC_UNIT_ACC_EN
    if (acc_sel_q) opa = d_q;
`endif
    case (op_q)
      3'b000:  res = opa & b_q;
      3'b001:  res = opa | b_q;
      3'b010:  res = opa ^ b_q;
      3'b011:  res = ~opa;
      3'b100:  res = ~(opa & b_q);
      3'b101:  res = ~(opa | b_q);
      3'b110:  res = ~(opa ^ b_q);
      default: res = b_q;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    s1_v_d      = s1_v_q;
    d_d         = d_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = out_valid_q;
`ifdef LOGIC_UNIT_ACC_EN
    acc_sel_d   = acc_sel_q;
`endif
    if (s1_load) begin
      a_d    = a;
      b_d    = b;
      op_d   = op;
      s1_v_d = 1'b1;
`ifdef LOGIC_UNIT_ACC_EN
      acc_sel_d = acc_sel;
`endif
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
    if (s2_load) begin
      d_d         = res;
      zero_d      = ~|res;
      parity_d    = ^res;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      s1_v_q      <= 1'b0;
      d_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef LOGIC_UNIT_ACC_EN
      acc_sel_q   <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      s1_v_q      <= s1_v_d;
      d_q         <= d_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
`ifdef LOGIC_UNIT_ACC_EN
      acc_sel_q   <= acc_sel_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule
